round_pipe: RTL and testbench
=============================

# round_pipe

Pipelined, handshaked successor to the combinational multiplier-output rounder in the PE datapath. It takes the raw mantissa product of the FP64/FP32/FP16 multiplier, normalises it by one position, and rounds it under a selectable rounding mode using a true guard/sticky rule. It returns the stored mantissa, exponent increment and status flags. It sits between the PE mantissa multiplier and the exponent/pack stage, and carries a sideband tag so the pack stage can re-associate results under back-pressure.

## Interface
- `WIDTH`, 106: product width. The FP64 field is `[WIDTH-1:WIDTH-106]`; WIDTH must be ≥106.
- `TAG_W`, 8: sideband tag width, passed through untouched.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `data_in`  in  WIDTH  unsigned mantissa product.
- `precision`  in  2  2'b10 FP64, 2'b01 FP32, 2'b00 FP16, 2'b11 reserved.
- `rnd_mode`  in  2  2'b00 RNE, 2'b01 RTZ, 2'b10 round-half-up (legacy), 2'b11 treated as RNE.
- `tag_in`  in  TAG_W  sideband.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `norm_out`  out  52  rounded fraction without the hidden bit, zero-extended for FP32/FP16.
- `exp_delta`  out  2  exponent increment, 0..2.
- `inexact`  out  1  guard or sticky was nonzero.
- `zero`  out  1  neither of the top two product bits is set; the result is forced to 0.
- `illegal`  out  1  the beat had reserved precision.
- `tag_out`  out  TAG_W  sideband.

## Operation
- Field selection, with `m` = top 106 bits:
  - FP64 uses `m[105:0]`, F=52.
  - FP32 uses `m[105:58]`, F=23.
  - FP16 uses `m[105:82]`, F=10.
  - Bits below the selected field are ignored and do not contribute to sticky.
- Normalisation, with `t` = top field bit:
  - If `t` is set: kept = next F bits, guard = following bit, sticky = OR of all remaining field bits, `s=1`.
  - Else if `t-1` is set: the same extraction one position lower, `s=0`.
  - Else: `zero=1`, `norm_out=0`, `exp_delta=0`, `inexact=0`.
- Increment rule:
  - RNE: `inc = g & (st | kept[0])`.
  - RTZ: `inc = 0`.
  - Half-up: `inc = g`.
- Arithmetic:
  - `sum = {1'b0,kept} + inc`, computed F+1 bits wide.
  - `c = sum[F]`.
  - `norm_out = c ? 0 : sum[F-1:0]`.
  - `exp_delta = s + c`.
- `inexact = g | st`.
- Reserved precision: `illegal=1`; all other result fields are 0, including `zero` and `inexact`.

## Timing
- Two register stages:
  - S1 captures the input fields and performs normalisation and guard/sticky extraction.
  - S2 holds the rounded result.
- Latency: a beat accepted in cycle N appears on the outputs in cycle N+2 if there is no stall.
- Throughput: one beat per cycle.
- Handshake:
  - A beat transfers on each port when valid and ready are both high.
  - Each stage advances when it is empty or its downstream stage is advancing.
  - `in_ready = !s1_valid | s1_advance`. A combinational `out_ready`→`in_ready` path is permitted.
- While `out_valid=1` and `out_ready=0`, all outputs must hold stable and no beat is lost or duplicated. With both stages full, `in_ready=0`.
- A simultaneous input accept and output pop when full keeps occupancy constant.
- Reset values:
  - `out_valid=0`, `in_ready=1` in the cycle after reset.
  - `norm_out=0`, `exp_delta=0`, all flags 0, `tag_out=0`.
- Reset asserted mid-operation discards all in-flight beats with no output pulse.
- Input beats presented while `rst=1` are not accepted.

## Structure
- `round_pkg` holds:
  - the precision encodings and rounding-mode encodings;
  - per-precision field offsets and F widths;
  - a result struct {norm, exp_delta, inexact, zero, illegal}.
- Sub-module `rnd_core` is purely combinational. It takes kept/guard/sticky/s/F-select/mode and returns the result struct. It is instantiated once, between S1 and S2.
- `round_pipe` owns the valid/ready pipeline control and the S1/S2 registers.

## Test plan
- **FP64 tie, RNE:** `m = (1<<104)|(1<<51)` → after 2 cycles `norm_out=0`, `exp_delta=0`, `inexact=1`. The same beat under half-up → `norm_out=1`.
- **FP64 carry:** `m[105]=1`, `m[104:53]` all ones, `m[52]=1`, RNE → `norm_out=0`, `exp_delta=2`, `inexact=1`. Under RTZ → `norm_out=52'hF_FFFF_FFFF_FFFF`, `exp_delta=1`.
- **FP32 odd-LSB tie:** `m[105:58]=48'h4000_00C0_0000`, RNE → `norm_out=2`, `exp_delta=0`, `inexact=1`. Nonzero bits in `m[57:0]` must not change the result.
- **Zero and reserved precision:** `m=0`, FP16 → `zero=1` with all other fields 0. `precision=2'b11` → only `illegal=1`.
- **Back-pressure:** stream 8 tagged beats (tags 0..7) while `out_ready` toggles 1,0,0,1,… → all 8 tags are delivered in order, outputs stay stable while stalled, and `in_ready=0` whenever both stages are full.
- **Reset mid-flight:** assert `rst` for one cycle with 2 beats in flight → no `out_valid` afterwards, `in_ready=1` in the next cycle, and a fresh beat then completes with 2-cycle latency.

Source files
------------

// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - shared encodings, field geometry and result type for round_pipe
package round_pkg;

  localparam int M_W    = 106;
  localparam int FRAC_W = 52;

  typedef enum logic [1:0] {
    PREC_FP16 = 2'b00,
    PREC_FP32 = 2'b01,
    PREC_FP64 = 2'b10,
    PREC_RSVD = 2'b11
  } prec_e;

  typedef enum logic [1:0] {
    RND_RNE     = 2'b00,
    RND_RTZ     = 2'b01,
    RND_HUP     = 2'b10,
    RND_RNE_ALT = 2'b11
  } rnd_e;

  localparam int F_FP64   = 52;
  localparam int F_FP32   = 23;
  localparam int F_FP16   = 10;
  localparam int LSB_FP64 = 0;
  localparam int LSB_FP32 = 58;
  localparam int LSB_FP16 = 82;

  typedef struct packed {
    logic [FRAC_W-1:0] norm;
    logic [1:0]        exp_delta;
    logic              inexact;
    logic              zero;
    logic              illegal;
  } rnd_result_t;

  // Clears product bits below the selected field so they never reach sticky.
  function automatic logic [M_W-1:0] field_mask(input prec_e p);
    case (p)
      PREC_FP32: field_mask = {M_W{1'b1}} << LSB_FP32;
      PREC_FP16: field_mask = {M_W{1'b1}} << LSB_FP16;
      default:   field_mask = {M_W{1'b1}} << LSB_FP64;
    endcase
  endfunction

endpackage

// File: rtl/rnd_core.sv
// rtl/rnd_core.sv - combinational increment/carry stage producing the rounded result
module rnd_core
  import round_pkg::*;
(
  input  logic [FRAC_W-1:0] i_kept,
  input  logic              i_guard,
  input  logic              i_sticky,
  input  logic              i_s,
  input  prec_e             i_prec,
  input  rnd_e              i_mode,
  input  logic              i_zero,
  input  logic              i_illegal,
  output rnd_result_t       o_res
);

  logic              w_inc;
  logic [FRAC_W:0]   w_sum;
  logic              w_c;

  always_comb begin
    w_inc = 1'b0;
    case (i_mode)
      RND_RTZ: w_inc = 1'b0;
      RND_HUP: w_inc = i_guard;
      default: w_inc = i_guard & (i_sticky | i_kept[0]);
    endcase
  end

  // Kept is zero-extended, so the carry for narrow formats lands at bit F.
  always_comb begin
    w_sum = {1'b0, i_kept} + {{FRAC_W{1'b0}}, w_inc};
    w_c   = 1'b0;
    case (i_prec)
      PREC_FP64: w_c = w_sum[F_FP64];
      PREC_FP32: w_c = w_sum[F_FP32];
      PREC_FP16: w_c = w_sum[F_FP16];
      default:   w_c = 1'b0;
    endcase
  end

  always_comb begin
    o_res = '0;
    if (i_illegal) begin
      o_res.illegal = 1'b1;
    end else if (i_zero) begin
      o_res.zero = 1'b1;
    end else begin
      o_res.norm      = w_c ? '0 : w_sum[FRAC_W-1:0];
      o_res.exp_delta = {1'b0, i_s} + {1'b0, w_c};
      o_res.inexact   = i_guard | i_sticky;
    end
  end

endmodule

// File: rtl/round_pipe.sv
// rtl/round_pipe.sv - two-stage handshaked normalise-and-round of multiplier mantissa products
module round_pipe
  import round_pkg::*;
#(
  parameter int WIDTH = 106,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [1:0]        precision,
  input  logic [1:0]        rnd_mode,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [51:0]       norm_out,
  output logic [1:0]        exp_delta,
  output logic              inexact,
  output logic              zero,
  output logic              illegal,
  output logic [TAG_W-1:0]  tag_out
);

  logic [M_W-1:0]    w_f;
  logic [M_W-2:0]    w_sh;
  logic              w_s, w_nz, w_g, w_st;
  logic [FRAC_W-1:0] w_kept;
  logic              w_s1_adv, w_s2_adv;
  rnd_result_t       w_res;

  logic              r1_valid, r1_s, r1_g, r1_st, r1_zero, r1_illegal;
  logic [FRAC_W-1:0] r1_kept;
  prec_e             r1_prec;
  rnd_e              r1_mode;
  logic [TAG_W-1:0]  r1_tag;
  logic              r2_valid;
  rnd_result_t       r2_res;
  logic [TAG_W-1:0]  r2_tag;

  // After masking, every field starts at bit 105, so one shift aligns both cases.
  always_comb begin
    w_f  = data_in[WIDTH-1 -: M_W] & field_mask(prec_e'(precision));
    w_s  = w_f[M_W-1];
    w_nz = w_f[M_W-1] | w_f[M_W-2];
    w_sh = w_s ? w_f[M_W-2:0] : {w_f[M_W-3:0], 1'b0};
    w_kept = '0;
    w_g    = 1'b0;
    w_st   = 1'b0;
    case (prec_e'(precision))
      PREC_FP64: begin
        w_kept = w_sh[104 -: F_FP64];
        w_g    = w_sh[104-F_FP64];
        w_st   = |w_sh[103-F_FP64:0];
      end
      PREC_FP32: begin
        w_kept = {{(FRAC_W-F_FP32){1'b0}}, w_sh[104 -: F_FP32]};
        w_g    = w_sh[104-F_FP32];
        w_st   = |w_sh[103-F_FP32:0];
      end
      PREC_FP16: begin
        w_kept = {{(FRAC_W-F_FP16){1'b0}}, w_sh[104 -: F_FP16]};
        w_g    = w_sh[104-F_FP16];
        w_st   = |w_sh[103-F_FP16:0];
      end
      default: ;
    endcase
  end

  assign w_s2_adv = !r2_valid | out_ready;
  assign w_s1_adv = !r1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  rnd_core u_rnd_core (
    .i_kept    (r1_kept),
    .i_guard   (r1_g),
    .i_sticky  (r1_st),
    .i_s       (r1_s),
    .i_prec    (r1_prec),
    .i_mode    (r1_mode),
    .i_zero    (r1_zero),
    .i_illegal (r1_illegal),
    .o_res     (w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid   <= 1'b0;
      r1_s       <= 1'b0;
      r1_g       <= 1'b0;
      r1_st      <= 1'b0;
      r1_zero    <= 1'b0;
      r1_illegal <= 1'b0;
      r1_kept    <= '0;
      r1_prec    <= PREC_FP16;
      r1_mode    <= RND_RNE;
      r1_tag     <= '0;
      r2_valid   <= 1'b0;
      r2_res     <= '0;
      r2_tag     <= '0;
    end else begin
      if (w_s1_adv) begin
        r1_valid <= in_valid;
        if (in_valid) begin
          r1_s       <= w_s;
          r1_g       <= w_g;
          r1_st      <= w_st;
          r1_zero    <= !w_nz;
          r1_illegal <= (prec_e'(precision) == PREC_RSVD);
          r1_kept    <= w_kept;
          r1_prec    <= prec_e'(precision);
          r1_mode    <= rnd_e'(rnd_mode);
          r1_tag     <= tag_in;
        end
      end
      if (w_s2_adv) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_res <= w_res;
          r2_tag <= r1_tag;
        end
      end
    end
  end

  assign out_valid = r2_valid;
  assign norm_out  = r2_res.norm;
  assign exp_delta = r2_res.exp_delta;
  assign inexact   = r2_res.inexact;
  assign zero      = r2_res.zero;
  assign illegal   = r2_res.illegal;
  assign tag_out   = r2_tag;

endmodule

// File: tb/tb_round_pipe.sv
// tb/tb_round_pipe.sv - directed self-checking bench for round_pipe
module tb_round_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [105:0] data_in;
  logic [1:0]   precision;
  logic [1:0]   rnd_mode;
  logic [7:0]   tag_in;
  logic         out_valid;
  logic         out_ready;
  logic [51:0]  norm_out;
  logic [1:0]   exp_delta;
  logic         inexact;
  logic         zero;
  logic         illegal;
  logic [7:0]   tag_out;

  int n_pass  = 0;
  int n_total = 0;

  int          sent, popped, occ;
  logic        acc, pop, held_v;
  logic [7:0]  held_tag;
  logic [51:0] held_norm;
  logic [105:0] m1, m2, m3, m3b, m4;

  round_pipe #(.WIDTH(106), .TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .precision (precision),
    .rnd_mode  (rnd_mode),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .norm_out  (norm_out),
    .exp_delta (exp_delta),
    .inexact   (inexact),
    .zero      (zero),
    .illegal   (illegal),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
    end
  endtask

  task automatic chk_res(input string nm, input logic [51:0] en, input logic [1:0] ed,
                         input logic ei, input logic ez, input logic eil);
    chk({nm, ".norm"},    64'(norm_out),  64'(en));
    chk({nm, ".exp"},     64'(exp_delta), 64'(ed));
    chk({nm, ".inexact"}, 64'(inexact),   64'(ei));
    chk({nm, ".zero"},    64'(zero),      64'(ez));
    chk({nm, ".illegal"}, 64'(illegal),   64'(eil));
  endtask

  // Called at a negedge with an empty input stage; returns when the result is on the outputs.
  task automatic beat(input string nm, input logic [105:0] d, input logic [1:0] p,
                      input logic [1:0] md, input logic [7:0] t);
    in_valid  = 1'b1;
    data_in   = d;
    precision = p;
    rnd_mode  = md;
    tag_in    = t;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, ".lat1_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({nm, ".lat2_valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".tag"},        64'(tag_out),   64'(t));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    data_in   = 106'd1 << 105;
    precision = 2'b10;
    rnd_mode  = 2'b00;
    tag_in    = 8'hAA;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.tag",       64'(tag_out),   64'd0);
    chk_res("rst", 52'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("no_accept_in_rst", 64'(out_valid), 64'd0);

    m1 = (106'd1 << 104) | (106'd1 << 51);
    beat("fp64_tie_rne", m1, 2'b10, 2'b00, 8'd1);
    chk_res("fp64_tie_rne", 52'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    beat("fp64_tie_hup", m1, 2'b10, 2'b10, 8'd2);
    chk_res("fp64_tie_hup", 52'd1, 2'd0, 1'b1, 1'b0, 1'b0);

    m2 = {1'b1, {52{1'b1}}, 1'b1, 52'd0};
    beat("fp64_carry_rne", m2, 2'b10, 2'b00, 8'd3);
    chk_res("fp64_carry_rne", 52'd0, 2'd2, 1'b1, 1'b0, 1'b0);
    beat("fp64_carry_rtz", m2, 2'b10, 2'b01, 8'd4);
    chk_res("fp64_carry_rtz", 52'hF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 1'b0, 1'b0);
    beat("fp64_carry_alt", m2, 2'b10, 2'b11, 8'd5);
    chk_res("fp64_carry_alt", 52'd0, 2'd2, 1'b1, 1'b0, 1'b0);

    m3  = {48'h4000_00C0_0000, 58'd0};
    m3b = {48'h4000_00C0_0000, {58{1'b1}}};
    beat("fp32_tie", m3, 2'b01, 2'b00, 8'd6);
    chk_res("fp32_tie", 52'd2, 2'd0, 1'b1, 1'b0, 1'b0);
    beat("fp32_lowjunk", m3b, 2'b01, 2'b00, 8'd7);
    chk_res("fp32_lowjunk", 52'd2, 2'd0, 1'b1, 1'b0, 1'b0);

    m4 = {24'hFFE001, {82{1'b1}}};
    beat("fp16_sticky", m4, 2'b00, 2'b00, 8'd8);
    chk_res("fp16_sticky", 52'h3FF, 2'd1, 1'b1, 1'b0, 1'b0);

    beat("fp16_zero", 106'd0, 2'b00, 2'b00, 8'd9);
    chk_res("fp16_zero", 52'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    beat("fp64_zero_low", 106'd1 << 103, 2'b10, 2'b10, 8'd10);
    chk_res("fp64_zero_low", 52'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    beat("rsvd", m2, 2'b11, 2'b10, 8'd11);
    chk_res("rsvd", 52'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    in_valid = 1'b0;
    @(negedge clk);
    sent   = 0;
    popped = 0;
    occ    = 0;
    held_v = 1'b0;
    precision = 2'b10;
    rnd_mode  = 2'b01;
    for (int cyc = 0; cyc < 80 && popped < 8; cyc++) begin
      if (held_v) begin
        chk("bp.stall_valid", 64'(out_valid), 64'd1);
        chk("bp.stall_tag",   64'(tag_out),   64'(held_tag));
        chk("bp.stall_norm",  64'(norm_out),  64'(held_norm));
      end
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < 8);
      data_in   = {1'b1, 52'(sent), 53'd0};
      tag_in    = 8'(sent);
      #1;
      chk("bp.in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        chk("bp.tag_order", 64'(tag_out),   64'(popped));
        chk("bp.norm",      64'(norm_out),  64'(popped));
        chk("bp.exp",       64'(exp_delta), 64'd1);
        popped++;
      end
      held_v    = out_valid && !out_ready;
      held_tag  = tag_out;
      held_norm = norm_out;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(pop);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp.all_popped", 64'(popped), 64'd8);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = m1;
    tag_in    = 8'd20;
    @(negedge clk);
    tag_in = 8'd21;
    @(negedge clk);
    chk("mid.full_valid",    64'(out_valid), 64'd1);
    chk("mid.full_in_ready", 64'(in_ready),  64'd0);
    rst    = 1'b1;
    tag_in = 8'd22;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("mid.out_valid", 64'(out_valid), 64'd0);
    chk("mid.in_ready",  64'(in_ready),  64'd1);
    chk("mid.tag",       64'(tag_out),   64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid.quiet", 64'(out_valid), 64'd0);
    end
    beat("post_rst", m1, 2'b10, 2'b10, 8'd23);
    chk_res("post_rst", 52'd1, 2'd0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
